// File: rtl/inst_fetch_reg.sv
// Instruction fetch + instruction register: owns the PC, fetches one word at a
// time over a req/resp handshake and holds it until downstream accepts it.
module inst_fetch_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    input  logic        inst_accept,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] count_q, count_d;
    logic        take;
    logic        redirect_lo_unused;

    // Targets are word aligned; the low two bits are dropped.
    assign redirect_lo_unused = ^redirect_pc[1:0];
    assign take = (state_q == S_HOLD) && inst_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:    if (mem_req_ready) state_d = S_WAIT;
            S_WAIT:   if (mem_resp_valid) state_d = S_HOLD;
            S_HOLD:   if (inst_accept) state_d = halt ? S_HALTED : S_REQ;
            S_HALTED: state_d = S_HALTED;
        endcase
    end

    always_comb begin
        mem_req_valid = (state_q == S_REQ);
        inst_valid    = (state_q == S_HOLD);
        halted        = (state_q == S_HALTED);
        mem_req_addr  = pc_q;
        pc_out        = pc_q;
        inst_out      = inst_q;
        inst_count    = count_q;
    end

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        count_d = count_q;
        if ((state_q == S_WAIT) && mem_resp_valid) begin
            inst_d = mem_resp_data;
        end
        if (take) begin
            count_d = count_q + 32'd1;
            if (!halt) begin
                pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00}
                                      : pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_reg.sv
// Self-checking bench for inst_fetch_reg: directed scenarios plus a randomized
// fetch stream compared against a PC/count reference model.
module tb_inst_fetch_reg;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        inst_accept = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] pc_out;
    logic        halted;
    logic [31:0] inst_count;

    int errors = 0;
    int checks = 0;

    inst_fetch_reg #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .inst_out(inst_out),
        .inst_valid(inst_valid), .inst_accept(inst_accept),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .pc_out(pc_out), .halted(halted),
        .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        inst_accept = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Runs one fetch from REQ to acceptance; returns what was seen on the way.
    task automatic do_fetch(input int rdly, input int lat, input int adly,
                            input logic rv, input logic [31:0] rpc,
                            input logic hl, input logic [31:0] data,
                            output logic [31:0] oaddr, output logic [31:0] oinst,
                            output logic [31:0] opc, output logic ovalid);
        for (int i = 0; i < rdly; i++) tick();
        oaddr = mem_req_addr;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = data;
        tick();
        mem_resp_valid = 1'b0;
        oinst = inst_out;
        opc = pc_out;
        ovalid = inst_valid;
        for (int i = 0; i < adly; i++) tick();
        inst_accept = 1'b1;
        redirect_valid = rv;
        redirect_pc = rpc;
        halt = hl;
        tick();
        inst_accept = 1'b0;
        redirect_valid = 1'b0;
        halt = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc_out !== RPC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, RPC); end
        checks++; if (inst_out !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", inst_out, NOP); end
        checks++; if ({inst_valid, halted, mem_req_valid} !== 3'b001) begin errors++; $display("FAIL reset_flags got %b exp 001", {inst_valid, halted, mem_req_valid}); end
        checks++; if (inst_count !== 32'd0) begin errors++; $display("FAIL reset_count got %h exp 0", inst_count); end
    endtask

    task automatic test_basic();
        logic [31:0] a, i, p;
        logic v;
        do_reset();
        do_fetch(0, 1, 0, 1'b0, 32'h0, 1'b0, 32'h0050_0093, a, i, p, v);
        checks++; if (a !== 32'h0) begin errors++; $display("FAIL basic_addr got %h exp 0", a); end
        checks++; if (i !== 32'h0050_0093 || v !== 1'b1) begin errors++; $display("FAIL basic_inst got %h/%b exp 00500093/1", i, v); end
        checks++; if (pc_out !== 32'h4 || mem_req_addr !== 32'h4) begin errors++; $display("FAIL basic_pc got %h/%h exp 4", pc_out, mem_req_addr); end
        checks++; if (inst_count !== 32'd1 || mem_req_valid !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL basic_next got cnt %h req %b iv %b exp 1/1/0", inst_count, mem_req_valid, inst_valid); end
    endtask

    task automatic test_req_stall();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data = 32'hDEAD_BEEF;
            inst_accept = 1'b1;
            tick();
            checks++; if (mem_req_valid !== 1'b1 || inst_valid !== 1'b0 || inst_out !== NOP) begin errors++; $display("FAIL req_stall got req %b iv %b inst %h exp 1/0/%h", mem_req_valid, inst_valid, inst_out, NOP); end
        end
        mem_resp_valid = 1'b0;
        inst_accept = 1'b0;
        checks++; if (inst_count !== 32'd0) begin errors++; $display("FAIL req_stall_count got %h exp 0", inst_count); end
    endtask

    task automatic test_hold();
        do_reset();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL wait_flags got %b%b exp 00", mem_req_valid, inst_valid); end
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h00A0_0113;
        tick();
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_req_ready = 1'b1;
            checks++; if (inst_out !== 32'h00A0_0113 || pc_out !== 32'h0 || inst_valid !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL hold got inst %h pc %h iv %b req %b", inst_out, pc_out, inst_valid, mem_req_valid); end
            tick();
        end
        mem_req_ready = 1'b0;
        inst_accept = 1'b1;
        tick();
        inst_accept = 1'b0;
        checks++; if (pc_out !== 32'h4 || inst_count !== 32'd1) begin errors++; $display("FAIL hold_accept got pc %h cnt %h exp 4/1", pc_out, inst_count); end
    endtask

    task automatic test_redirect_halt();
        logic [31:0] a, i, p;
        logic v;
        do_reset();
        for (int k = 0; k < 4; k++) do_fetch(0, 1, 0, 1'b0, 32'h0, 1'b0, 32'h13, a, i, p, v);
        checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL pre_redirect_pc got %h exp 10", pc_out); end
        do_fetch(0, 2, 1, 1'b1, 32'h0000_0103, 1'b0, 32'h13, a, i, p, v);
        checks++; if (pc_out !== 32'h100 || mem_req_addr !== 32'h100 || mem_req_valid !== 1'b1) begin errors++; $display("FAIL redirect got pc %h addr %h req %b exp 100", pc_out, mem_req_addr, mem_req_valid); end
        do_fetch(1, 1, 0, 1'b1, 32'h20, 1'b0, 32'h13, a, i, p, v);
        checks++; if (a !== 32'h100 || pc_out !== 32'h20) begin errors++; $display("FAIL redirect2 got addr %h pc %h exp 100/20", a, pc_out); end
        do_fetch(0, 1, 0, 1'b1, 32'h400, 1'b1, 32'h0000_0073, a, i, p, v);
        for (int k = 0; k < 3; k++) begin
            mem_req_ready = 1'b1;
            mem_resp_valid = 1'b1;
            inst_accept = 1'b1;
            checks++; if (halted !== 1'b1 || pc_out !== 32'h20 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL halted got h %b pc %h req %b iv %b", halted, pc_out, mem_req_valid, inst_valid); end
            tick();
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        inst_accept = 1'b0;
        checks++; if (inst_count !== 32'd7 || inst_out !== 32'h0000_0073) begin errors++; $display("FAIL halted_frozen got cnt %h inst %h exp 7/73", inst_count, inst_out); end
        do_reset();
        checks++; if (pc_out !== RPC || halted !== 1'b0 || inst_count !== 32'd0 || mem_req_valid !== 1'b1) begin errors++; $display("FAIL halt_reset got pc %h h %b cnt %h req %b", pc_out, halted, inst_count, mem_req_valid); end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] a, i, p;
        logic v;
        do_reset();
        do_fetch(0, 1, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h13, a, i, p, v);
        checks++; if (mem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", mem_req_addr); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h0000_0013;
        tick();
        mem_resp_valid = 1'b0;
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        inst_accept = 1'b1;
        tick();
        inst_accept = 1'b0;
        checks++; if (pc_out !== 32'h0 || inst_count !== 32'h0) begin errors++; $display("FAIL wrap got pc %h cnt %h exp 0/0", pc_out, inst_count); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data = 32'hBAD0_BAD0;
            tick();
        end
        mem_resp_valid = 1'b0;
        checks++; if (inst_out !== NOP || inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || pc_out !== RPC) begin errors++; $display("FAIL wait_reset got inst %h iv %b req %b pc %h", inst_out, inst_valid, mem_req_valid, pc_out); end
        do_fetch(0, 1, 0, 1'b0, 32'h0, 1'b0, 32'h1234_5678, a, i, p, v);
        checks++; if (a !== RPC || i !== 32'h1234_5678) begin errors++; $display("FAIL restart got addr %h inst %h exp %h/12345678", a, i, RPC); end
    endtask

    task automatic test_random();
        logic [31:0] a, i, p, data, tgt, exp_pc, exp_cnt;
        logic v, rv;
        do_reset();
        exp_pc = RPC;
        exp_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            data = $urandom;
            tgt = $urandom;
            rv = ($urandom_range(3) == 0);
            do_fetch($urandom_range(3), $urandom_range(4, 1), $urandom_range(3),
                     rv, tgt, 1'b0, data, a, i, p, v);
            checks++; if (a !== exp_pc || p !== exp_pc) begin errors++; $display("FAIL rand_pc[%0d] got addr %h pc %h exp %h", n, a, p, exp_pc); end
            checks++; if (i !== data || v !== 1'b1) begin errors++; $display("FAIL rand_inst[%0d] got %h/%b exp %h/1", n, i, v, data); end
            exp_cnt = exp_cnt + 1;
            exp_pc = rv ? (tgt & 32'hFFFF_FFFC) : exp_pc + 4;
            checks++; if (inst_count !== exp_cnt || pc_out !== exp_pc) begin errors++; $display("FAIL rand_next[%0d] got cnt %h pc %h exp %h/%h", n, inst_count, pc_out, exp_cnt, exp_pc); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_req_stall();
        test_hold();
        test_redirect_halt();
        test_wrap_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
